// File: rtl/uart_calc_fsm.sv
// Command/response controller: parses "<op><hex digits>\r\n" from a UART RX stream, updates an accumulator,
// and answers with a ROM message, the accumulator in hex and CR LF. Optional inter-byte timeout: UART_CALC_TIMEOUT_EN.
module uart_calc_fsm #(
  parameter int               OPD_DIGITS = 8,
  parameter int               ACC_W      = 92,
  parameter logic [ACC_W-1:0] ACC_INIT   = ACC_W'(8),
  parameter int               TO_CYCLES  = 1000000
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             rx_valid_i,
  input  logic [9:0]       rx_data_i,
  output logic             tx_valid_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i,
  output logic [2:0]       msg_id_o,
  output logic [5:0]       msg_idx_o,
  input  logic [7:0]       msg_data_i,
  input  logic             msg_last_i,
  output logic             busy_o,
  output logic [ACC_W-1:0] acc_o
);

  localparam int OPD_W      = 4 * OPD_DIGITS;
  localparam int RES_DIGITS = (ACC_W + 3) / 4;
  localparam int PAD_W      = 4 * RES_DIGITS;
  localparam int DIG_W      = $clog2(OPD_DIGITS + 1);
  localparam int RES_W      = $clog2(RES_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RDIG, S_RCR, S_RLF, S_TMSG, S_TRES, S_TCR, S_TLF
  } state_e;

  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB, OP_XOR} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [OPD_W-1:0] operand_q, operand_d;
  logic [DIG_W-1:0] digCnt_q, digCnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]       msgId_q, msgId_d;
  logic [5:0]       msgIdx_q, msgIdx_d;
  logic [RES_W-1:0] resIdx_q, resIdx_d;

  logic [7:0]       rxByte;
  logic             rxFrame, rxParity, rxState, rxTake, fmtErr;
  logic [2:0]       errCode;
  logic [4:0]       dec;
  logic             busy, hs;
  logic [ACC_W-1:0] opExt, accNext;
  logic [PAD_W-1:0] accShift;
  logic [3:0]       resNib;

  // Returns {valid, nibble}; letters map via their low nibble plus 9.
  function automatic logic [4:0] hexDecode(input logic [7:0] c);
    hexDecode = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)
      hexDecode = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      hexDecode = {1'b1, c[3:0] + 4'd9};
  endfunction

  function automatic logic [7:0] hexEncode(input logic [3:0] n);
    if (n < 4'd10) hexEncode = {4'h3, n};
    else           hexEncode = 8'h37 + {4'h0, n};
  endfunction

  assign rxByte   = rx_data_i[7:0];
  assign rxParity = rx_data_i[8];
  assign rxFrame  = rx_data_i[9];
  assign rxState  = (state_q inside {S_IDLE, S_RDIG, S_RCR, S_RLF});
  assign rxTake   = rx_valid_i && rxState;
  assign busy     = (state_q inside {S_TMSG, S_TRES, S_TCR, S_TLF});
  assign hs       = busy && tx_ready_i;
  assign dec      = hexDecode(rxByte);

  always_comb begin
    if (rxFrame && rxParity) errCode = 3'd4;
    else if (rxFrame)        errCode = 3'd3;
    else if (rxParity)       errCode = 3'd2;
    else                     errCode = 3'd1;
  end

  if (OPD_W >= ACC_W) begin : gOpTrunc
    assign opExt = operand_q[ACC_W-1:0];
  end else begin : gOpExt
    assign opExt = {{(ACC_W-OPD_W){1'b0}}, operand_q};
  end

  always_comb begin
    accNext = acc_q;
    case (op_q)
      OP_ADD:  accNext = acc_q + opExt;
      OP_SUB:  accNext = acc_q - opExt;
      OP_XOR:  accNext = acc_q ^ opExt;
      default: accNext = acc_q;
    endcase
  end

  assign accShift = PAD_W'(acc_q) >> (4 * (RES_DIGITS - 1 - int'(resIdx_q)));
  assign resNib   = accShift[3:0];

`ifdef UART_CALC_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            toFire;

  // Counts idle cycles while mid-line; any received byte restarts it.
  always_comb begin
    toCnt_d = '0;
    toFire  = 1'b0;
    if ((state_q inside {S_RDIG, S_RCR, S_RLF}) && !rx_valid_i) begin
      if (toCnt_q == TO_W'(TO_CYCLES - 1)) toFire = 1'b1;
      else                                 toCnt_d = toCnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) toCnt_q <= '0;
    else         toCnt_q <= toCnt_d;
  end
`else
  if (TO_CYCLES > 0) begin : gNoTimeout
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    digCnt_d  = digCnt_q;
    acc_d     = acc_q;
    msgId_d   = msgId_q;
    msgIdx_d  = msgIdx_q;
    resIdx_d  = resIdx_q;
    fmtErr    = 1'b0;

    case (state_q)
      S_IDLE: if (rx_valid_i) begin
        case (rxByte)
          8'h2B:   begin op_d = OP_ADD; state_d = S_RDIG; end
          8'h2D:   begin op_d = OP_SUB; state_d = S_RDIG; end
          8'h5E:   begin op_d = OP_XOR; state_d = S_RDIG; end
          8'h3D:   begin op_d = OP_NOP; state_d = S_RCR;  end
          default: fmtErr = 1'b1;
        endcase
      end
      S_RDIG: if (rx_valid_i) begin
        if (dec[4]) begin
          operand_d = (operand_q << 4) | OPD_W'(dec[3:0]);
          if (digCnt_q == DIG_W'(OPD_DIGITS - 1)) begin
            digCnt_d = '0;
            state_d  = S_RCR;
          end else begin
            digCnt_d = digCnt_q + DIG_W'(1);
          end
        end else begin
          fmtErr = 1'b1;
        end
      end
      S_RCR: if (rx_valid_i) begin
        if (rxByte == 8'h0D) state_d = S_RLF;
        else                 fmtErr  = 1'b1;
      end
      S_RLF: if (rx_valid_i) begin
        if (rxByte == 8'h0A) begin
          acc_d     = accNext;
          operand_d = '0;
          op_d      = OP_NOP;
          msgId_d   = 3'd0;
          msgIdx_d  = 6'd0;
          state_d   = S_TMSG;
        end else begin
          fmtErr = 1'b1;
        end
      end
      S_TMSG: if (hs) begin
        if (msg_last_i) begin
          msgIdx_d = 6'd0;
          resIdx_d = '0;
          state_d  = (msgId_q == 3'd0) ? S_TRES : S_TCR;
        end else begin
          msgIdx_d = msgIdx_q + 6'd1;
        end
      end
      S_TRES: if (hs) begin
        if (resIdx_q == RES_W'(RES_DIGITS - 1)) begin
          resIdx_d = '0;
          state_d  = S_TCR;
        end else begin
          resIdx_d = resIdx_q + RES_W'(1);
        end
      end
      S_TCR: if (hs) state_d = S_TLF;
      S_TLF: if (hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line errors override whatever the byte would otherwise have done, including an LF commit.
    if (rxTake && (rxFrame || rxParity || fmtErr)) begin
      acc_d     = acc_q;
      operand_d = '0;
      digCnt_d  = '0;
      op_d      = OP_NOP;
      msgId_d   = errCode;
      msgIdx_d  = 6'd0;
      state_d   = S_TMSG;
    end
`ifdef UART_CALC_TIMEOUT_EN
    if (toFire) begin
      operand_d = '0;
      digCnt_d  = '0;
      op_d      = OP_NOP;
      msgId_d   = 3'd5;
      msgIdx_d  = 6'd0;
      state_d   = S_TMSG;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      operand_q <= '0;
      digCnt_q  <= '0;
      acc_q     <= ACC_INIT;
      msgId_q   <= 3'd0;
      msgIdx_q  <= 6'd0;
      resIdx_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      digCnt_q  <= digCnt_d;
      acc_q     <= acc_d;
      msgId_q   <= msgId_d;
      msgIdx_q  <= msgIdx_d;
      resIdx_q  <= resIdx_d;
    end
  end

  // Byte source follows the state directly, so it holds still for as long as the transmitter stalls.
  always_comb begin
    tx_data_o = 8'h00;
    case (state_q)
      S_TMSG:  tx_data_o = msg_data_i;
      S_TRES:  tx_data_o = hexEncode(resNib);
      S_TCR:   tx_data_o = 8'h0D;
      S_TLF:   tx_data_o = 8'h0A;
      default: tx_data_o = 8'h00;
    endcase
  end

  assign tx_valid_o = busy;
  assign busy_o     = busy;
  assign msg_id_o   = msgId_q;
  assign msg_idx_o  = msgIdx_q;
  assign acc_o      = acc_q;

endmodule

// File: tb/tb_uart_calc_fsm.sv
// Randomised scoreboard bench for uart_calc_fsm (2-digit operands, 8-bit accumulator, reset value 0x08).
module tb_uart_calc_fsm;

  localparam int ACC_W = 8;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             rx_valid_i;
  logic [9:0]       rx_data_i;
  logic             tx_valid_o;
  logic [7:0]       tx_data_o;
  logic             tx_ready_i;
  logic [2:0]       msg_id_o;
  logic [5:0]       msg_idx_o;
  logic [7:0]       msg_data_i;
  logic             msg_last_i;
  logic             busy_o;
  logic [ACC_W-1:0] acc_o;

  uart_calc_fsm #(
    .OPD_DIGITS(2),
    .ACC_W     (ACC_W),
    .ACC_INIT  (8'h08)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .msg_id_o   (msg_id_o),
    .msg_idx_o  (msg_idx_o),
    .msg_data_i (msg_data_i),
    .msg_last_i (msg_last_i),
    .busy_o     (busy_o),
    .acc_o      (acc_o)
  );

  always #5 clk_i = ~clk_i;

  // Message ROM: "OK " for id 0, "E<n> " otherwise.
  always_comb begin
    msg_data_i = 8'h00;
    msg_last_i = (msg_idx_o == 6'd2);
    case (msg_idx_o)
      6'd0:    msg_data_i = (msg_id_o == 3'd0) ? 8'h4F : 8'h45;
      6'd1:    msg_data_i = (msg_id_o == 3'd0) ? 8'h4B : (8'h30 + {5'd0, msg_id_o});
      6'd2:    msg_data_i = 8'h20;
      default: msg_data_i = 8'h00;
    endcase
  end

  logic [7:0] expQ[$];
  logic [9:0] lineQ[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  int         popCount = 0;
  int         readyMode = 0;
  int         accModel = 8;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Transmitter back-pressure: 0 always ready, 1 one-on/two-off, 2 random, 3 held low.
  initial begin : readyDriver
    int cyc;
    cyc = 0;
    tx_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      case (readyMode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = (cyc % 3 == 0);
        2:       tx_ready_i = 1'($urandom_range(0, 1));
        default: tx_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted TX byte is popped from the scoreboard; stalled bytes must hold.
  always @(negedge clk_i) begin : monitor
    logic       prevStall;
    logic [7:0] stallData;
    logic [7:0] e;
    if (!rstn_i) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        testsRun++;
        if (!(tx_valid_o && tx_data_o == stallData)) begin
          testsFailed++;
          $display("[TB] FAIL tx_stall_hold: got valid=%0b data=%02h expected valid=1 data=%02h",
                   tx_valid_o, tx_data_o, stallData);
        end
      end
      if (tx_valid_o && tx_ready_i) begin
        testsRun++;
        popCount++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL tx_unexpected: got %02h expected no byte", tx_data_o);
        end else begin
          e = expQ.pop_front();
          if (tx_data_o !== e) begin
            testsFailed++;
            $display("[TB] FAIL tx_byte: got %02h expected %02h", tx_data_o, e);
          end
        end
      end
      prevStall = tx_valid_o && !tx_ready_i;
      stallData = tx_data_o;
    end
  end

  function automatic logic [7:0] hexAny(input int n, input bit lower);
    if (n < 10) return 8'(48 + n);
    return lower ? 8'(97 + n - 10) : 8'(65 + n - 10);
  endfunction

  function automatic int applyOp(input logic [7:0] op, input int acc, input int val);
    case (op)
      8'h2B:   return (acc + val) & 255;
      8'h2D:   return (acc - val) & 255;
      8'h5E:   return acc ^ val;
      default: return acc;
    endcase
  endfunction

  task automatic pushOk();
    expQ.push_back(8'h4F); expQ.push_back(8'h4B); expQ.push_back(8'h20);
    expQ.push_back(hexAny(accModel / 16, 1'b0));
    expQ.push_back(hexAny(accModel % 16, 1'b0));
    expQ.push_back(8'h0D); expQ.push_back(8'h0A);
  endtask

  task automatic pushErr(input int id);
    expQ.push_back(8'h45); expQ.push_back(8'(48 + id)); expQ.push_back(8'h20);
    expQ.push_back(8'h0D); expQ.push_back(8'h0A);
  endtask

  // Drives one RX byte for one cycle; called and returns at posedge+1.
  task automatic applyStimulus(input logic [9:0] v);
    rx_valid_i = 1'b1;
    rx_data_i  = v;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 10'd0;
  endtask

  task automatic loadString(input string s);
    lineQ.delete();
    for (int i = 0; i < s.len(); i++) lineQ.push_back({2'b00, s[i]});
  endtask

  // First nMain bytes go out with random gaps; anything after them follows back-to-back.
  task automatic issue(input int nMain, input int gapMax);
    for (int i = 0; i < lineQ.size(); i++) begin
      if (i > 0 && i < nMain) repeat ($urandom_range(0, gapMax)) begin @(posedge clk_i); #1; end
      applyStimulus(lineQ[i]);
    end
  endtask

  task automatic finishCmd(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk_i);
      if (expQ.size() == 0 && !busy_o) done = 1'b1;
    end
    checkOutput({name, "_idle"}, 32'(done), 32'd1);
    if (!done) expQ.delete();
    checkOutput({name, "_acc"}, 32'(acc_o), 32'(accModel));
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] badFor(input int pos, input int size);
    logic [7:0] nonHex[7];
    nonHex = '{8'h2F, 8'h3A, 8'h40, 8'h47, 8'h60, 8'h67, 8'h0D};
    if (pos == 0)        return 8'h2A;
    if (pos == size - 1) return 8'h0D;
    if (pos == size - 2) return 8'h41;
    return nonHex[$urandom_range(0, 6)];
  endfunction

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [7:0] ops[4];
    logic [7:0] op;
    logic [9:0] b;
    int val, errPos, errKind, nMain, base;
    ops = '{8'h2B, 8'h2D, 8'h5E, 8'h3D};

    rstn_i     = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 10'd0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    checkOutput("rst_tx_data",  32'(tx_data_o),  32'd0);
    checkOutput("rst_msg_id",   32'(msg_id_o),   32'd0);
    checkOutput("rst_msg_idx",  32'(msg_idx_o),  32'd0);
    checkOutput("rst_busy",     32'(busy_o),     32'd0);
    checkOutput("rst_acc",      32'(acc_o),      32'h08);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Subtract below zero, with busy observed around the LF.
    readyMode = 0;
    loadString("-09\r\n");
    accModel = applyOp(8'h2D, accModel, 9);
    pushOk();
    for (int i = 0; i < 4; i++) applyStimulus(lineQ[i]);
    checkOutput("busy_before_lf", 32'(busy_o), 32'd0);
    applyStimulus(lineQ[4]);
    checkOutput("busy_after_lf", 32'(busy_o), 32'd1);
    finishCmd("sub_wrap");
    checkOutput("sub_wrap_const", 32'(acc_o), 32'hFF);

    loadString("+fF\r\n");
    accModel = applyOp(8'h2B, accModel, 255);
    pushOk();
    issue(lineQ.size(), 0);
    finishCmd("add_wrap");
    checkOutput("add_wrap_const", 32'(acc_o), 32'hFE);

    readyMode = 1;
    loadString("^A5\r\n");
    accModel = applyOp(8'h5E, accModel, 8'hA5);
    pushOk();
    issue(lineQ.size(), 0);
    finishCmd("xor_stall");

    readyMode = 0;
    loadString("+3G\r\n");
    pushErr(1);
    issue(3, 0);
    finishCmd("fmt_err");

    loadString("=\r\n");
    pushOk();
    issue(lineQ.size(), 0);
    finishCmd("query");

    loadString("+5\r\n");
    lineQ[1] = {2'b11, 8'h35};
    pushErr(4);
    issue(2, 0);
    finishCmd("frame_parity");

    // Random commands, some with a single injected fault.
    for (int n = 0; n < 60; n++) begin
      readyMode = $urandom_range(0, 2);
      op  = ops[$urandom_range(0, 3)];
      val = $urandom_range(0, 255);
      lineQ.delete();
      lineQ.push_back({2'b00, op});
      if (op != 8'h3D) begin
        lineQ.push_back({2'b00, hexAny(val / 16, 1'($urandom_range(0, 1)))});
        lineQ.push_back({2'b00, hexAny(val % 16, 1'($urandom_range(0, 1)))});
      end
      lineQ.push_back(10'h00D);
      lineQ.push_back(10'h00A);
      if ($urandom_range(0, 2) == 0) begin
        errPos  = $urandom_range(0, lineQ.size() - 1);
        errKind = $urandom_range(0, 3);
        b = lineQ[errPos];
        case (errKind)
          0:       b = {2'b00, badFor(errPos, lineQ.size())};
          1:       b[8] = 1'b1;
          2:       b[9] = 1'b1;
          default: b[9:8] = 2'b11;
        endcase
        lineQ[errPos] = b;
        while (lineQ.size() > errPos + 1) void'(lineQ.pop_back());
        repeat ($urandom_range(0, 2)) lineQ.push_back(10'h00D);
        pushErr(errKind + 1);
        nMain = errPos + 1;
      end else begin
        accModel = applyOp(op, accModel, val);
        pushOk();
        nMain = lineQ.size();
      end
      issue(nMain, 2);
      finishCmd("random");
    end

    // Reset while stalled on the first result digit.
    readyMode = 0;
    loadString("=\r\n");
    pushOk();
    base = popCount;
    issue(lineQ.size(), 0);
    for (int i = 0; i < 100 && popCount < base + 3; i++) @(posedge clk_i);
    readyMode = 3;
    checkOutput("tres_reached", 32'(popCount >= base + 3), 32'd1);
    @(posedge clk_i);
    #1;
    checkOutput("tres_stall_valid", 32'(tx_valid_o), 32'd1);
    checkOutput("tres_stall_digit", 32'(tx_data_o), 32'(hexAny(accModel / 16, 1'b0)));
    rstn_i = 1'b0;
    #1;
    checkOutput("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
    checkOutput("midrst_acc",      32'(acc_o),      32'h08);
    checkOutput("midrst_busy",     32'(busy_o),     32'd0);
    expQ.delete();
    accModel = 8;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    readyMode = 0;
    @(posedge clk_i);
    #1;

    loadString("-03\r\n");
    accModel = applyOp(8'h2D, accModel, 3);
    pushOk();
    issue(lineQ.size(), 0);
    finishCmd("post_reset");
    checkOutput("post_reset_const", 32'(acc_o), 32'h05);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
